// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard sequencer: per-register control word,
// sequencer states and trap cause codes.
package pack;

   typedef struct packed {
      logic stall;
      logic flush;
   } control;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      ENTER
   } hazardState;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

   localparam control CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
   localparam control CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
   localparam control CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_controller_load_use.sv
// Load-use detector: the instruction in Decode reads a register that the
// load currently in Execute has not yet produced.
module load_use_detector (
   input  logic       executeValid,
   input  logic       executeLoad,
   input  logic [4:0] executeRd,
   input  logic       decodeValid,
   input  logic [4:0] decodeRs1,
   input  logic [4:0] decodeRs2,
   output logic       hazard
);

   // x0 is never a real dependency, so a load targeting it cannot stall Decode
   assign hazard = executeValid && executeLoad && (executeRd != 5'd0) && decodeValid
                   && ((executeRd == decodeRs1) || (executeRd == decodeRs2));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stall/flush per pipeline register, PC redirection,
// illegal-instruction traps and drained external-interrupt entry.
//
// state | meaning
// RUN   | normal issue; hazards resolved by priority each cycle
// DRAIN | interrupt pending; fetch held while older instructions retire
// ENTER | one cycle: redirect to the trap vector and commit the interrupt
module hazard_controller
   import pack::*;
#(
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        interrupt,
   input  logic [31:0] fetchPc,
   input  logic        decodeValid,
   input  logic [4:0]  decodeRs1,
   input  logic [4:0]  decodeRs2,
   input  logic        executeValid,
   input  logic [4:0]  executeRd,
   input  logic        executeLoad,
   input  logic        redirectValid,
   input  logic [31:0] redirectTarget,
   input  logic        illegalValid,
   input  logic [31:0] illegalPc,
   input  logic        memoryBusy,
   output control      fetchControl,
   output control      fetchDecodeControl,
   output control      decodeExecuteControl,
   output control      executeMemoryControl,
   output control      memoryWritebackControl,
   output logic        pcRedirectValid,
   output logic [31:0] pcRedirectTarget,
   output logic        trapActive,
   output logic [31:0] trapPc,
   output logic [31:0] trapCause
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   hazardState    state;
   logic [CW-1:0] drain_count;
   logic [31:0]   resume_pc;
   logic          load_use;

   load_use_detector u_load_use (
      .executeValid (executeValid),
      .executeLoad  (executeLoad),
      .executeRd    (executeRd),
      .decodeValid  (decodeValid),
      .decodeRs1    (decodeRs1),
      .decodeRs2    (decodeRs2),
      .hazard       (load_use)
   );

   always_comb begin
      fetchControl           = CTRL_NONE;
      fetchDecodeControl     = CTRL_NONE;
      decodeExecuteControl   = CTRL_NONE;
      executeMemoryControl   = CTRL_NONE;
      memoryWritebackControl = CTRL_NONE;
      pcRedirectValid        = 1'b0;
      pcRedirectTarget       = 32'd0;
      if (!reset) begin
         fetchControl           = CTRL_FLUSH;
         fetchDecodeControl     = CTRL_FLUSH;
         decodeExecuteControl   = CTRL_FLUSH;
         executeMemoryControl   = CTRL_FLUSH;
         memoryWritebackControl = CTRL_FLUSH;
      end else if (state == ENTER) begin
         fetchDecodeControl = CTRL_FLUSH;
         pcRedirectValid    = 1'b1;
         pcRedirectTarget   = TRAP_VECTOR;
      end else if (memoryBusy) begin
         // memory back-pressure freezes everything upstream, even in DRAIN
         fetchControl           = CTRL_STALL;
         fetchDecodeControl     = CTRL_STALL;
         decodeExecuteControl   = CTRL_STALL;
         executeMemoryControl   = CTRL_STALL;
         memoryWritebackControl = CTRL_FLUSH;
      end else if (illegalValid) begin
         fetchDecodeControl     = CTRL_FLUSH;
         decodeExecuteControl   = CTRL_FLUSH;
         executeMemoryControl   = CTRL_FLUSH;
         memoryWritebackControl = CTRL_FLUSH;
         pcRedirectValid        = 1'b1;
         pcRedirectTarget       = TRAP_VECTOR;
      end else if (state == DRAIN) begin
         // a branch resolving while draining updates the resume point instead of the PC
         fetchControl       = CTRL_STALL;
         fetchDecodeControl = CTRL_FLUSH;
         if (redirectValid) decodeExecuteControl = CTRL_FLUSH;
      end else if (redirectValid) begin
         fetchDecodeControl   = CTRL_FLUSH;
         decodeExecuteControl = CTRL_FLUSH;
         pcRedirectValid      = 1'b1;
         pcRedirectTarget     = redirectTarget;
      end else if (load_use) begin
         fetchControl         = CTRL_STALL;
         fetchDecodeControl   = CTRL_STALL;
         decodeExecuteControl = CTRL_FLUSH;
      end else if (interrupt) begin
         fetchControl       = CTRL_STALL;
         fetchDecodeControl = CTRL_FLUSH;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= RUN;
         drain_count <= '0;
         resume_pc   <= 32'd0;
         trapPc      <= 32'd0;
         trapCause   <= 32'd0;
         trapActive  <= 1'b0;
      end else begin
         trapActive <= 1'b0;
         case (state)
            RUN: begin
               if (!memoryBusy) begin
                  if (illegalValid) begin
                     trapPc     <= illegalPc;
                     trapCause  <= CAUSE_ILLEGAL;
                     trapActive <= 1'b1;
                  end else if (!redirectValid && !load_use && interrupt) begin
                     resume_pc   <= fetchPc;
                     drain_count <= DRAIN_LOAD;
                     state       <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!memoryBusy) begin
                  if (illegalValid) begin
                     trapPc      <= illegalPc;
                     trapCause   <= CAUSE_ILLEGAL;
                     trapActive  <= 1'b1;
                     drain_count <= '0;
                     state       <= RUN;
                  end else begin
                     if (redirectValid) resume_pc <= redirectTarget;
                     if (drain_count == '0) state <= ENTER;
                     else drain_count <= drain_count - 1'b1;
                  end
               end
            end
            ENTER: begin
               trapPc     <= resume_pc;
               trapCause  <= CAUSE_EXT_IRQ;
               trapActive <= 1'b1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scenarios followed by random traffic, all checked against a
// cycle-level reference model of the sequencing rules.
module tb_hazard_controller;
   import pack::*;

   logic        clock = 1'b0;
   logic        reset, interrupt, decodeValid, executeValid, executeLoad;
   logic        redirectValid, illegalValid, memoryBusy;
   logic [31:0] fetchPc, redirectTarget, illegalPc;
   logic [4:0]  decodeRs1, decodeRs2, executeRd;
   control      fetchControl, fetchDecodeControl, decodeExecuteControl;
   control      executeMemoryControl, memoryWritebackControl;
   logic        pcRedirectValid, trapActive;
   logic [31:0] pcRedirectTarget, trapPc, trapCause;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   hazard_controller dut (
      .clock(clock), .reset(reset), .interrupt(interrupt), .fetchPc(fetchPc),
      .decodeValid(decodeValid), .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
      .executeValid(executeValid), .executeRd(executeRd), .executeLoad(executeLoad),
      .redirectValid(redirectValid), .redirectTarget(redirectTarget),
      .illegalValid(illegalValid), .illegalPc(illegalPc), .memoryBusy(memoryBusy),
      .fetchControl(fetchControl), .fetchDecodeControl(fetchDecodeControl),
      .decodeExecuteControl(decodeExecuteControl), .executeMemoryControl(executeMemoryControl),
      .memoryWritebackControl(memoryWritebackControl),
      .pcRedirectValid(pcRedirectValid), .pcRedirectTarget(pcRedirectTarget),
      .trapActive(trapActive), .trapPc(trapPc), .trapCause(trapCause)
   );

   // model: mode 0 = running, 1 = draining (m_left cycles still to retire), 2 = entering
   int          m_mode = 0;
   int          m_left = 0;
   logic [31:0] m_resume = 0, m_tpc = 0, m_tcause = 0;
   logic        m_tact = 0;
   // per-cycle expectation; bit 0 fetch, 1 F/D, 2 D/E, 3 E/M, 4 M/W
   logic [4:0]  e_st, e_fl;
   logic        e_rv;
   logic [31:0] e_tgt;
   logic        ev_ill, ev_irq_commit, ev_start, ev_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_comb();
      logic lu;
      lu = executeValid && executeLoad && executeRd != 0 && decodeValid
           && (executeRd == decodeRs1 || executeRd == decodeRs2);
      e_st = 5'b0; e_fl = 5'b0; e_rv = 0; e_tgt = 0;
      ev_ill = 0; ev_irq_commit = 0; ev_start = 0; ev_tick = 0;
      if (!reset) e_fl = 5'b11111;
      else if (m_mode == 2) begin
         e_fl = 5'b00010; e_rv = 1; e_tgt = 32'h100; ev_irq_commit = 1;
      end else if (memoryBusy) begin
         e_st = 5'b01111; e_fl = 5'b10000;
      end else if (illegalValid) begin
         e_fl = 5'b11110; e_rv = 1; e_tgt = 32'h100; ev_ill = 1;
      end else if (m_mode == 1) begin
         e_st = 5'b00001; e_fl = redirectValid ? 5'b00110 : 5'b00010; ev_tick = 1;
      end else if (redirectValid) begin
         e_fl = 5'b00110; e_rv = 1; e_tgt = redirectTarget;
      end else if (lu) begin
         e_st = 5'b00011; e_fl = 5'b00100;
      end else if (interrupt) begin
         e_st = 5'b00001; e_fl = 5'b00010; ev_start = 1;
      end
   endtask

   task automatic model_edge();
      m_tact = 0;
      if (!reset) begin
         m_mode = 0; m_left = 0; m_resume = 0; m_tpc = 0; m_tcause = 0;
      end else if (ev_irq_commit) begin
         m_tpc = m_resume; m_tcause = 32'h8000_000B; m_tact = 1; m_mode = 0;
      end else if (ev_ill) begin
         m_tpc = illegalPc; m_tcause = 32'd2; m_tact = 1; m_mode = 0;
      end else if (ev_start) begin
         m_resume = fetchPc; m_left = 3; m_mode = 1;
      end else if (ev_tick) begin
         if (redirectValid) m_resume = redirectTarget;
         m_left--;
         if (m_left == 0) m_mode = 2;
      end
   endtask

   task automatic step();
      logic [4:0] o_st, o_fl;
      #1;
      model_comb();
      o_st = {memoryWritebackControl.stall, executeMemoryControl.stall,
              decodeExecuteControl.stall, fetchDecodeControl.stall, fetchControl.stall};
      o_fl = {memoryWritebackControl.flush, executeMemoryControl.flush,
              decodeExecuteControl.flush, fetchDecodeControl.flush, fetchControl.flush};
      chk("stall_mask", 32'(o_st), 32'(e_st));
      chk("flush_mask", 32'(o_fl), 32'(e_fl));
      chk("redirect_valid", 32'(pcRedirectValid), 32'(e_rv));
      if (e_rv) chk("redirect_target", pcRedirectTarget, e_tgt);
      @(posedge clock);
      model_edge();
      #1;
      chk("trap_active", 32'(trapActive), 32'(m_tact));
      chk("trap_pc", trapPc, m_tpc);
      chk("trap_cause", trapCause, m_tcause);
   endtask

   task automatic idle();
      reset = 1; interrupt = 0; fetchPc = 32'h40; decodeValid = 0; decodeRs1 = 0; decodeRs2 = 0;
      executeValid = 0; executeRd = 0; executeLoad = 0; redirectValid = 0; redirectTarget = 0;
      illegalValid = 0; illegalPc = 0; memoryBusy = 0;
   endtask

   initial begin
      idle();
      reset = 0;
      step(); step();
      chk("reset_trap_pc", trapPc, 32'h0);
      chk("reset_fetch_flush", 32'(fetchControl.flush), 32'd1);
      reset = 1;
      step();

      // load-use: lw x5 in EX, add x6,x5,x1 in Decode
      executeValid = 1; executeLoad = 1; executeRd = 5; decodeValid = 1; decodeRs1 = 5; decodeRs2 = 1;
      #1;
      chk("load_use_fetch_stall", 32'(fetchControl.stall), 32'd1);
      chk("load_use_de_flush", 32'(decodeExecuteControl.flush), 32'd1);
      step();
      executeRd = 0; decodeRs1 = 0;
      #1;
      chk("x0_no_stall", 32'(fetchControl.stall), 32'd0);
      step();
      idle();

      // taken branch
      redirectValid = 1; redirectTarget = 32'h200;
      #1;
      chk("branch_target", pcRedirectTarget, 32'h200);
      step();
      idle();
      step();
      chk("branch_one_cycle", 32'(decodeExecuteControl.flush), 32'd0);

      // illegal instruction trap
      illegalValid = 1; illegalPc = 32'h48;
      step();
      chk("illegal_pc", trapPc, 32'h48);
      chk("illegal_cause", trapCause, 32'd2);
      chk("illegal_pulse", 32'(trapActive), 32'd1);
      idle();
      step();
      chk("illegal_pulse_end", 32'(trapActive), 32'd0);

      // interrupt; request drops during drain but entry still happens
      fetchPc = 32'h80; interrupt = 1;
      step();
      interrupt = 0;
      for (int i = 0; i < 3; i++) step();
      chk("irq_enter_redirect", 32'(pcRedirectValid), 32'd1);
      chk("irq_enter_target", pcRedirectTarget, 32'h100);
      step();
      chk("irq_trap_pc", trapPc, 32'h80);
      chk("irq_cause", trapCause, 32'h8000_000B);

      // interrupt with a branch resolving during drain
      interrupt = 1; fetchPc = 32'h90;
      step();
      interrupt = 0; redirectValid = 1; redirectTarget = 32'h300;
      step();
      idle();
      step(); step(); step();
      chk("irq_redirect_resume", trapPc, 32'h300);

      // busy dominates illegal and branch; illegal is taken once busy drops
      memoryBusy = 1; illegalValid = 1; illegalPc = 32'h64; redirectValid = 1; redirectTarget = 32'h500;
      #1;
      chk("prio_no_redirect", 32'(pcRedirectValid), 32'd0);
      chk("prio_mw_flush", 32'(memoryWritebackControl.flush), 32'd1);
      step();
      memoryBusy = 0;
      step();
      chk("prio_trap_pc", trapPc, 32'h64);
      idle();
      step();

      // reset in the middle of a drain discards the interrupt
      interrupt = 1;
      step();
      interrupt = 0;
      step();
      reset = 0;
      step();
      chk("rst_drain_pc", trapPc, 32'h0);
      reset = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_drain_no_trap", 32'(trapActive), 32'd0);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 99) != 0);
         interrupt      = ($urandom_range(0, 99) < 25);
         memoryBusy     = ($urandom_range(0, 99) < 15);
         illegalValid   = ($urandom_range(0, 99) < 5);
         redirectValid  = ($urandom_range(0, 99) < 12);
         executeValid   = 1'($urandom);
         executeLoad    = 1'($urandom);
         decodeValid    = 1'($urandom);
         executeRd      = 5'($urandom_range(0, 3));
         decodeRs1      = 5'($urandom_range(0, 3));
         decodeRs2      = 5'($urandom_range(0, 3));
         fetchPc        = $urandom & 32'hFFFF_FFFC;
         redirectTarget = $urandom & 32'hFFFF_FFFC;
         illegalPc      = $urandom & 32'hFFFF_FFFC;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central pipeline sequencer for the in-order 5-stage core. It turns hazard and exception indications from Decode, Execute and Memory into per-register `control` (stall/flush) values. It also owns PC redirection for taken branches/jumps, illegal-instruction traps and external interrupts. Sits beside the pipeline registers; every stage's `control` input is driven from here.

## Interface
- `TRAP_VECTOR`, 32'h0000_0100, handler address for all traps
- `DRAIN_CYCLES`, 3, cycles needed to retire Decode/Execute/Memory contents before interrupt entry

- `clock` in 1: sole clock
- `reset` in 1: synchronous, active-low
- `interrupt` in 1: level-sensitive external interrupt request
- `fetchPc` in 32: PC currently in Fetch
- `decodeValid` in 1, `decodeRs1`/`decodeRs2` in 5 each: Decode's valid and register read addresses (0 when unused)
- `executeValid` in 1, `executeRd` in 5, `executeLoad` in 1: ID/EX payload valid, destinationRegister, memoryReadEnable
- `redirectValid` in 1, `redirectTarget` in 32: Execute-resolved taken branch/jump
- `illegalValid` in 1, `illegalPc` in 32: valid illegal instruction in the Memory stage
- `memoryBusy` in 1: data memory not ready this cycle
- `fetchControl`, `fetchDecodeControl`, `decodeExecuteControl`, `executeMemoryControl`, `memoryWritebackControl` out `control`: stall/flush per stage
- `pcRedirectValid` out 1, `pcRedirectTarget` out 32: next-PC override
- `trapActive` out 1: one-cycle pulse on trap commit
- `trapPc` out 32, `trapCause` out 32: registered mepc/mcause values

## Operation
- FSM states: RUN, DRAIN, ENTER.
- RUN priority, highest first; only the highest active event applies:
  1. `memoryBusy`: stall fetch, F/D, D/E, E/M; flush M/W (bubble).
  2. `illegalValid`: flush F/D, D/E, E/M, M/W; redirect to TRAP_VECTOR. Next edge: `trapPc`←`illegalPc`, `trapCause`←32'd2, `trapActive`=1 for one cycle.
  3. `redirectValid`: flush F/D and D/E; redirect to `redirectTarget`.
  4. Load-use: fires when `executeValid && executeLoad && executeRd!=0 && decodeValid` and (`executeRd==decodeRs1` or `executeRd==decodeRs2`). Response: stall fetch and F/D, flush D/E.
  5. `interrupt`, none of the above: latch `resumePc`←`fetchPc`, load drain counter with DRAIN_CYCLES-1, go to DRAIN. Stall fetch, flush F/D.
- DRAIN:
  - fetch stalled, F/D flushed every cycle.
  - Counter decrements only when `memoryBusy`=0. While busy, apply the RUN rule 1 stall pattern.
  - `redirectValid`: `resumePc`←`redirectTarget`, flush D/E. Counter continues.
  - `illegalValid`: abandon interrupt and perform the RUN rule 2 trap. Return to RUN.
  - Counter at 0 with no busy: go to ENTER.
- ENTER, one cycle: redirect to TRAP_VECTOR, flush F/D. `trapPc`←`resumePc`, `trapCause`←32'h8000_000B, `trapActive` next cycle. Return to RUN.
- `interrupt` dropping during DRAIN does not cancel entry.
- Stall and flush are never both 1 for the same register.

## Timing
- All control and redirect outputs are combinational from state plus inputs. Same-cycle effect at the next clock edge.
- Load-use inserts exactly one bubble.
- Branch penalty is two cycles.
- Interrupt entry latency, with no busy: 1 (RUN) + DRAIN_CYCLES + 1 (ENTER) cycles.
- Reset (`reset`=0 at edge), regardless of state:
  - state RUN, counter 0.
  - `trapPc`, `trapCause`, `resumePc` = 0; `trapActive` = 0.
  - While `reset`=0: all controls flush=1/stall=0, `pcRedirectValid`=0.
- Reset during DRAIN discards the pending interrupt.

## Structure
- `pack` gains: `hazardState` enum (RUN/DRAIN/ENTER), the cause constants `CAUSE_ILLEGAL` and `CAUSE_EXT_IRQ`, and reuses the existing `control` struct.
- One sub-module, `load_use_detector`: purely combinational, implements rule 4.
- FSM, counter and trap registers live in `hazard_controller`.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in Decode → one cycle with fetch/F/D stall and D/E flush. With `executeRd`=0 → no stall.
- Branch: `redirectValid`=1, target 0x200 → `pcRedirectTarget`=0x200, F/D and D/E flush=1 that cycle only.
- Illegal: `illegalValid` at `illegalPc`=0x48 → redirect to 0x100 and all four registers flushed. Next cycle `trapPc`=0x48, `trapCause`=2, `trapActive`=1 for one cycle.
- Interrupt: `fetchPc`=0x80, interrupt asserted → ENTER reached after 4 cycles. `trapPc`=0x80, `trapCause`=0x8000000B. With `redirectValid`(0x300) during DRAIN → `trapPc`=0x300.
- Priority: `memoryBusy`, `illegalValid` and `redirectValid` all 1 in the same cycle → stall-only pattern. Drop busy → illegal trap taken.
- Reset: assert `reset`=0 mid-DRAIN → RUN, registers zero, no `trapActive` after release.
